// File: rtl/jpeg_zz_scan_sched.sv
// jpeg_zz_scan_sched
//
// Reads 8x8 DCT coefficient blocks out of a dual-bank coefficient buffer in
// JPEG zigzag order and feeds them to a single downstream quantizer/entropy
// datapath. Luma (bank 0) and chroma (bank 1) requesters share the datapath
// through a round-robin arbiter. A 2-entry output FIFO absorbs downstream
// backpressure across the buffer's 1-cycle read latency.
//
// Optional feature (macro JPEG_ZZ_ZRUN_EN): zero AC coefficients at zigzag
// index 1..62 are dropped from the output stream and out_zrun reports how
// many were dropped immediately before each emitted beat.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   req_y, req_c   level block requests for luma / chroma
//   done_y, done_c one-cycle completion pulses
//   buf_rd_en      buffer read strobe
//   buf_sel        bank select for the read (0 luma, 1 chroma)
//   buf_addr       raster address {row, col}
//   buf_rdata      read data, valid the cycle after buf_rd_en
//   out_valid/out_ready  output handshake
//   out_coef, out_idx, out_comp, out_last  output beat payload
//   out_zrun       suppressed-zero run length (JPEG_ZZ_ZRUN_EN only)
//   busy           high whenever a block is being handled

module jpeg_zz_scan_sched #(
    parameter int   COEF_W  = 12,
    parameter logic RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_y,
    input  logic              req_c,
    output logic              done_y,
    output logic              done_c,
    output logic              buf_rd_en,
    output logic              buf_sel,
    output logic [5:0]        buf_addr,
    input  logic [COEF_W-1:0] buf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COEF_W-1:0] out_coef,
    output logic [5:0]        out_idx,
    output logic              out_comp,
    output logic              out_last,
`ifdef JPEG_ZZ_ZRUN_EN
    output logic [5:0]        out_zrun,
`endif
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Zigzag index -> raster address {row, col}.
    localparam logic [5:0] ZZ_ROM [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    state_t            state, state_nx;
    logic              rr_ptr;
    logic              sel;
    logic [5:0]        zz;
    logic              rd_pend;
    logic [5:0]        rd_pend_idx;

    logic [COEF_W-1:0] fifo_coef [2];
    logic [5:0]        fifo_idx  [2];
    logic [1:0]        fifo_comp;
    logic [1:0]        fifo_last;
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;

    logic              fifo_ne;
    logic              consume;
    logic              grant_c;
    logic [2:0]        occ_left;

    // Head of the FIFO drives the output payload directly.
    assign out_coef = fifo_coef[rd_ptr];
    assign out_idx  = fifo_idx[rd_ptr];
    assign out_comp = fifo_comp[rd_ptr];
    assign out_last = fifo_last[rd_ptr];
    assign fifo_ne  = (count != 2'd0);

`ifdef JPEG_ZZ_ZRUN_EN
    logic       suppress;
    logic [5:0] zrun;

    // DC and the final coefficient are always emitted so the block framing survives.
    assign suppress  = fifo_ne && (fifo_coef[rd_ptr] == '0) &&
                       (fifo_idx[rd_ptr] != 6'd0) && (fifo_idx[rd_ptr] != 6'd63);
    assign out_valid = fifo_ne && !suppress;
    assign consume   = fifo_ne && (suppress || out_ready);
    assign out_zrun  = zrun;
`else
    assign out_valid = fifo_ne;
    assign consume   = fifo_ne && out_ready;
`endif

    // A read may issue only if the FIFO has room when its data returns. Counting
    // this cycle's pop keeps full rate with out_ready high, at the cost of a
    // combinational path from out_ready to buf_rd_en.
    assign occ_left  = {1'b0, count} - {2'b0, consume} + {2'b0, rd_pend};
    assign buf_rd_en = (state == S_SCAN) && (occ_left < 3'd2);
    assign buf_addr  = (state == S_SCAN) ? ZZ_ROM[zz] : 6'd0;
    assign buf_sel   = sel;
    assign done_y    = (state == S_DONE) && !sel;
    assign done_c    = (state == S_DONE) && sel;
    assign busy      = (state != S_IDLE);
    assign grant_c   = (req_y && req_c) ? rr_ptr : req_c;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req_y || req_c) state_nx = S_GRANT;
            S_GRANT: state_nx = S_SCAN;
            S_SCAN:  if (buf_rd_en && (zz == 6'd63)) state_nx = S_DRAIN;
            S_DRAIN: if (consume && fifo_last[rd_ptr]) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= RR_INIT;
            sel         <= 1'b0;
            zz          <= 6'd0;
            rd_pend     <= 1'b0;
            rd_pend_idx <= 6'd0;
        end else begin
            state       <= state_nx;
            rd_pend     <= buf_rd_en;
            rd_pend_idx <= zz;
            if (state == S_GRANT) begin
                sel <= grant_c;
                zz  <= 6'd0;
            end else if (buf_rd_en) begin
                zz <= zz + 6'd1;
            end
            if (state == S_DONE) rr_ptr <= ~sel;
        end
    end

    // Capture returning read data; the in-flight index tags each beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_coef[0] <= '0;
            fifo_coef[1] <= '0;
            fifo_idx[0]  <= 6'd0;
            fifo_idx[1]  <= 6'd0;
            fifo_comp    <= 2'b00;
            fifo_last    <= 2'b00;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
        end else begin
            if (rd_pend) begin
                fifo_coef[wr_ptr] <= buf_rdata;
                fifo_idx[wr_ptr]  <= rd_pend_idx;
                fifo_comp[wr_ptr] <= sel;
                fifo_last[wr_ptr] <= (rd_pend_idx == 6'd63);
                wr_ptr            <= ~wr_ptr;
            end
            if (consume) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, rd_pend} - {1'b0, consume};
        end
    end

`ifdef JPEG_ZZ_ZRUN_EN
    always_ff @(posedge clk) begin
        if (rst || (state == S_GRANT)) begin
            zrun <= 6'd0;
        end else if (consume) begin
            zrun <= suppress ? zrun + 6'd1 : 6'd0;
        end
    end
`endif

endmodule

// File: tb/tb_jpeg_zz_scan_sched.sv
// tb_jpeg_zz_scan_sched
//
// Scoreboard bench for jpeg_zz_scan_sched. Stimulus tasks fill the buffer
// model, predict whole blocks from a zigzag walk of the 8x8 grid and push the
// expected beats/done pulses into queues; a monitor pops and compares them.

module tb_jpeg_zz_scan_sched;

    localparam int   COEF_W  = 12;
    localparam logic RR_INIT = 1'b0;

    typedef struct {
        logic [COEF_W-1:0] coef;
        int                idx;
        logic              comp;
        logic              last;
        int                zrun;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_y = 1'b0, req_c = 1'b0;
    logic              done_y, done_c, buf_rd_en, buf_sel;
    logic [5:0]        buf_addr;
    logic [COEF_W-1:0] buf_rdata = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [COEF_W-1:0] out_coef;
    logic [5:0]        out_idx;
    logic              out_comp, out_last, busy;
`ifdef JPEG_ZZ_ZRUN_EN
    logic [5:0]        out_zrun;
`endif

    logic [COEF_W-1:0] mem [2][64];
    int                zz_order [64];
    beat_t             exp_q [$];
    int                done_q [$];

    int   checks = 0, errors = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    bit   ptr = RR_INIT;
    int   hold_c_extra = 0;
    int   done_cnt_y = 0, done_cnt_c = 0;
    int   done_cyc = 0, done_c_cyc = 0, prev_done_c_cyc = 0;
    int   start_cyc = 0, first_valid_cyc = 0;
    bit   first_valid_seen = 0;
    int   beats_seen = 0;
    bit   last_was_last = 0;
    int   issued = 0, accepted = 0;

    jpeg_zz_scan_sched #(.COEF_W(COEF_W), .RR_INIT(RR_INIT)) dut (
        .clk(clk), .rst(rst), .req_y(req_y), .req_c(req_c),
        .done_y(done_y), .done_c(done_c),
        .buf_rd_en(buf_rd_en), .buf_sel(buf_sel), .buf_addr(buf_addr),
        .buf_rdata(buf_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_coef(out_coef), .out_idx(out_idx), .out_comp(out_comp),
        .out_last(out_last),
`ifdef JPEG_ZZ_ZRUN_EN
        .out_zrun(out_zrun),
`endif
        .busy(busy)
    );

    // Free-running 100 MHz clock and a cycle counter used for latency checks.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Coefficient buffer model: one cycle of read latency from the strobe.
    always @(posedge clk) if (buf_rd_en) buf_rdata <= mem[buf_sel][buf_addr];

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Zigzag order derived by walking anti-diagonals of the 8x8 grid,
    // alternating direction on each diagonal.
    task automatic buildOrder();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz_order[k] = r * 8 + (s - r); k++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz_order[k] = r * 8 + (s - r); k++; end
            end
        end
    endtask

    // mode 0: coef = raster address, 1: random with some zeros, 2: sparse (0, 9, 63)
    task automatic fillBank(input int comp, input int mode);
        logic [31:0] r;
        for (int a = 0; a < 64; a++) begin
            r = $urandom;
            case (mode)
                0:       mem[comp][a] = COEF_W'(a);
                1:       mem[comp][a] = ($urandom_range(0, 3) == 0) ? '0 : r[COEF_W-1:0];
                default: mem[comp][a] = (a == 0 || a == 9 || a == 63) ? COEF_W'(a + 100) : '0;
            endcase
        end
    endtask

    task automatic predictBlock(input int comp);
        beat_t b;
        int run = 0;
        for (int k = 0; k < 64; k++) begin
            b.coef = mem[comp][zz_order[k]];
`ifdef JPEG_ZZ_ZRUN_EN
            if (b.coef == '0 && k != 0 && k != 63) begin
                run++;
                continue;
            end
`endif
            b.idx  = k;
            b.comp = comp[0];
            b.last = (k == 63);
            b.zrun = run;
            exp_q.push_back(b);
            run = 0;
        end
        done_q.push_back(comp);
    endtask

    // Issue requests and predict the block order from the round-robin rule.
    task automatic applyStimulus(input bit ry, input bit rc, input int extra_c);
        @(posedge clk); #1;
        if (ry && rc) begin
            predictBlock(int'(ptr));
            predictBlock(int'(!ptr));
        end else if (ry) begin
            predictBlock(0);
            ptr = 1'b1;
        end else begin
            for (int i = 0; i <= extra_c; i++) predictBlock(1);
            ptr = 1'b0;
        end
        hold_c_extra     = extra_c;
        start_cyc        = cyc + 1;
        first_valid_seen = 0;
        req_y = ry;
        req_c = rc;
    endtask

    task automatic waitDones(input int ny, input int nc, input int budget);
        int ty = done_cnt_y + ny;
        int tc = done_cnt_c + nc;
        int n  = 0;
        while ((done_cnt_y < ty || done_cnt_c < tc) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) checkOutput("done_timeout", 0, 1);
    endtask

    task automatic checkResetValues();
        checkOutput("rst_done_y", done_y, 0);
        checkOutput("rst_done_c", done_c, 0);
        checkOutput("rst_buf_rd_en", buf_rd_en, 0);
        checkOutput("rst_buf_sel", buf_sel, 0);
        checkOutput("rst_buf_addr", buf_addr, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_coef", out_coef, 0);
        checkOutput("rst_out_idx", out_idx, 0);
        checkOutput("rst_out_comp", out_comp, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_busy", busy, 0);
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1; req_y = 1'b0; req_c = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        done_q.delete();
        ptr          = RR_INIT;
        hold_c_extra = 0;
        checkResetValues();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Downstream ready driver: always-ready, the 1,0,0,1 pattern, or random.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin out_ready = (ph == 0 || ph == 3); ph = (ph + 1) % 4; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares accepted beats and done pulses against the scoreboard,
    // checks payload stability under stall, and releases requests after done.
    initial begin
        beat_t b;
        beat_t held;
        bit    stalled = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled  = 0;
                issued   = 0;
                accepted = 0;
            end else begin
                if (stalled) begin
                    checkOutput("stall_valid", out_valid, 1);
                    checkOutput("stall_coef", out_coef, held.coef);
                    checkOutput("stall_idx", out_idx, held.idx);
                    checkOutput("stall_last", out_last, held.last);
                end
                stalled   = out_valid && !out_ready;
                held.coef = out_coef;
                held.idx  = out_idx;
                held.last = out_last;
`ifndef JPEG_ZZ_ZRUN_EN
                if (busy) checkOutput("fifo_plus_inflight_le2", (issued - accepted) <= 2, 1);
                if (buf_rd_en) issued++;
                if (out_valid && out_ready) accepted++;
`endif
                if (out_valid && !first_valid_seen) begin
                    first_valid_seen = 1;
                    first_valid_cyc  = cyc;
                end
                if (out_valid && out_ready) begin
                    beats_seen++;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_beat", 1, 0);
                    end else begin
                        b = exp_q.pop_front();
                        checkOutput("beat_coef", out_coef, b.coef);
                        checkOutput("beat_idx", out_idx, b.idx);
                        checkOutput("beat_comp", out_comp, b.comp);
                        checkOutput("beat_last", out_last, b.last);
`ifdef JPEG_ZZ_ZRUN_EN
                        checkOutput("beat_zrun", out_zrun, b.zrun);
`endif
                    end
                    last_was_last = out_last;
                end
                if (done_y || done_c) begin
                    done_cyc = cyc;
                    checkOutput("done_one_hot", done_y && done_c, 0);
                    checkOutput("done_after_last_beat", last_was_last, 1);
                    if (done_q.size() == 0) checkOutput("unexpected_done", 1, 0);
                    else checkOutput("done_comp", done_c, done_q.pop_front());
                    last_was_last = 0;
                    if (done_y) begin
                        done_cnt_y++;
                        req_y = 1'b0;
                    end
                    if (done_c) begin
                        done_cnt_c++;
                        prev_done_c_cyc = done_c_cyc;
                        done_c_cyc      = cyc;
                        if (hold_c_extra > 0) hold_c_extra--;
                        else req_c = 1'b0;
                    end
                end
            end
        end
    end

    // Test sequence.
    initial begin
        int dy;
        int n;
        buildOrder();
        doReset();

        $display("[TB] single luma block, raster pattern, no stalls");
        ready_mode = 0;
        fillBank(0, 0);
        applyStimulus(1, 0, 0);
        waitDones(1, 0, 300);
        checkOutput("first_valid_latency", first_valid_cyc - start_cyc, 3);
        checkOutput("done_latency", done_cyc - start_cyc, 67);

        $display("[TB] simultaneous requests after reset, then rotated priority");
        doReset();
        fillBank(0, 1); fillBank(1, 1);
        applyStimulus(1, 1, 0);
        waitDones(1, 1, 400);
        fillBank(0, 1);
        applyStimulus(1, 0, 0);
        waitDones(1, 0, 300);
        fillBank(0, 1); fillBank(1, 1);
        applyStimulus(1, 1, 0);
        waitDones(1, 1, 400);

        $display("[TB] backpressure: 1,0,0,1 pattern then random");
        ready_mode = 1;
        fillBank(1, 1);
        applyStimulus(0, 1, 0);
        waitDones(0, 1, 600);
        ready_mode = 2;
        fillBank(0, 1);
        applyStimulus(1, 0, 0);
        waitDones(1, 0, 1000);

        $display("[TB] reset in the middle of a block");
        fillBank(0, 1);
        beats_seen = 0;
        applyStimulus(1, 0, 0);
        n = 0;
        while (beats_seen < 30 && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) checkOutput("beat30_timeout", 0, 1);
        dy = done_cnt_y;
        doReset();
        repeat (80) @(negedge clk);
        checkOutput("no_done_after_abort", done_cnt_y - dy, 0);
        ready_mode = 0;
        fillBank(1, 1);
        applyStimulus(0, 1, 0);
        waitDones(0, 1, 300);

        $display("[TB] sparse block");
        fillBank(0, 2);
        applyStimulus(1, 0, 0);
        waitDones(1, 0, 300);

        $display("[TB] chroma request held across two blocks");
        fillBank(1, 1);
        applyStimulus(0, 1, 1);
        waitDones(0, 2, 600);
        checkOutput("back_to_back_done_spacing", done_c_cyc - prev_done_c_cyc, 69);
        checkOutput("first_chained_done_latency", prev_done_c_cyc - start_cyc, 67);

        repeat (10) @(negedge clk);
        checkOutput("idle_at_end", busy, 0);
        checkOutput("beats_outstanding", exp_q.size(), 0);
        checkOutput("dones_outstanding", done_q.size(), 0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
